// File: rtl/pc_gen.sv
// Fetch-pair PC generator: holds the PC pair, handshakes fetch requests and queues redirects behind a held request.
// Optional build macro PC_GEN_STAT_EN adds saturating prediction/redirect statistics counters.
`ifndef BR_WD
`define BR_WD 33
`endif

module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      new_pc,
  input  logic [`BR_WD-1:0] br_bus,
  input  logic [`BR_WD-1:0] bp_bus,
  input  logic             next_inst_invalid,
  output logic [31:0]      current_pc1,
  output logic [31:0]      current_pc2,
  output logic             inst_req,
  input  logic             inst_addr_ok,
  output logic [1:0]       fetch_mask,
  output logic             kill_inflight
`ifdef PC_GEN_STAT_EN
  ,
  output logic [31:0]      stat_bp_taken,
  output logic [31:0]      stat_redirect
`endif
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_flush_q, pend_flush_d;

  logic        br_e, bp_e;
  logic [31:0] br_target, bp_target;
  logic        accept, may_update, redirect_apply;

  assign br_e      = br_bus[`BR_WD-1];
  assign br_target = br_bus[31:0];
  assign bp_e      = bp_bus[`BR_WD-1];
  assign bp_target = bp_bus[31:0];

  assign accept         = (state_q == REQ) && inst_addr_ok;
  assign may_update     = (state_q == IDLE) || accept;
  assign redirect_apply = may_update && (flush || pend_v_q || br_e);

  assign current_pc1   = pc_q;
  assign current_pc2   = pc_q + 32'd4;
  assign inst_req      = (state_q == REQ);
  assign fetch_mask    = redirect_apply ? 2'b00 : {~(bp_e & next_inst_invalid), 1'b1};
  assign kill_inflight = resetn && (flush || br_e);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_v_d     = pend_v_q;
    pend_pc_d    = pend_pc_q;
    pend_flush_d = pend_flush_q;

    case (state_q)
      IDLE:    if (!stall) state_d = REQ;
      REQ:     if (accept) state_d = stall ? IDLE : REQ;
      default: state_d = IDLE;
    endcase

    if (may_update) begin
      pend_v_d     = 1'b0;
      pend_flush_d = 1'b0;
      if (flush)              pc_d = new_pc;
      else if (pend_v_q)      pc_d = pend_pc_q;
      else if (br_e)          pc_d = br_target;
      else if (accept && bp_e) pc_d = bp_target;
      else if (accept)        pc_d = pc_q + 32'd8;
    end else begin
      // Request held on the bus: PC must stay put, so park the redirect.
      if (flush) begin
        pend_v_d     = 1'b1;
        pend_pc_d    = new_pc;
        pend_flush_d = 1'b1;
      end else if (br_e && !pend_flush_q) begin
        pend_v_d     = 1'b1;
        pend_pc_d    = br_target;
        pend_flush_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      pend_v_q     <= 1'b0;
      pend_pc_q    <= 32'd0;
      pend_flush_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_v_q     <= pend_v_d;
      pend_pc_q    <= pend_pc_d;
      pend_flush_q <= pend_flush_d;
    end
  end

`ifdef PC_GEN_STAT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stat_bp_taken <= 32'd0;
      stat_redirect <= 32'd0;
    end else begin
      if (accept && bp_e && !redirect_apply && (stat_bp_taken != 32'hFFFF_FFFF))
        stat_bp_taken <= stat_bp_taken + 32'd1;
      if (br_e && (stat_redirect != 32'hFFFF_FFFF))
        stat_redirect <= stat_redirect + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: stimulus queues expected accepted pairs and direct observations; a monitor checks them.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        resetn, stall, flush, next_inst_invalid, inst_addr_ok;
  logic [31:0] new_pc;
  logic [32:0] br_bus, bp_bus;
  logic [31:0] current_pc1, current_pc2;
  logic        inst_req, kill_inflight;
  logic [1:0]  fetch_mask;
`ifdef PC_GEN_STAT_EN
  logic [31:0] stat_bp_taken, stat_redirect;
`endif

  pc_gen dut (
    .clk(clk), .resetn(resetn), .stall(stall), .flush(flush), .new_pc(new_pc),
    .br_bus(br_bus), .bp_bus(bp_bus), .next_inst_invalid(next_inst_invalid),
    .current_pc1(current_pc1), .current_pc2(current_pc2), .inst_req(inst_req),
    .inst_addr_ok(inst_addr_ok), .fetch_mask(fetch_mask), .kill_inflight(kill_inflight)
`ifdef PC_GEN_STAT_EN
    , .stat_bp_taken(stat_bp_taken), .stat_redirect(stat_redirect)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] pc1; logic [31:0] pc2; logic [1:0] mask;} acc_t;
  typedef struct {string name; logic [31:0] act; logic [31:0] exp;} obs_t;

  acc_t exp_q[$];
  obs_t obs_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    obs_q.push_back('{name, act, exp});
  endtask

  task automatic expect_acc(input logic [31:0] pc1, input logic [31:0] pc2, input logic [1:0] mask);
    exp_q.push_back('{pc1, pc2, mask});
  endtask

  // Monitor: compares queued observations and every accepted fetch pair.
  initial begin
    obs_t o;
    acc_t e;
    forever begin
      @(negedge clk);
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        total++;
        if (o.act !== o.exp) begin
          bad++;
          $display("FAIL %s: got %h want %h", o.name, o.act, o.exp);
        end
      end
      if (inst_req && inst_addr_ok) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_accept: got pc1=%h want no acceptance", current_pc1);
        end else begin
          e = exp_q.pop_front();
          if ({current_pc1, current_pc2, fetch_mask} !== {e.pc1, e.pc2, e.mask}) begin
            bad++;
            $display("FAIL accept_pair: got pc1=%h pc2=%h mask=%b want pc1=%h pc2=%h mask=%b",
                     current_pc1, current_pc2, fetch_mask, e.pc1, e.pc2, e.mask);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; stall = 1'b0; flush = 1'b0; new_pc = 32'd0;
    br_bus = 33'd0; bp_bus = 33'd0; next_inst_invalid = 1'b0; inst_addr_ok = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc1", current_pc1, 32'hBFC0_0000);
    chk("rst_pc2", current_pc2, 32'hBFC0_0004);
    chk("rst_req", {31'd0, inst_req}, 32'd0);
    chk("rst_kill", {31'd0, kill_inflight}, 32'd0);
    resetn = 1'b1; inst_addr_ok = 1'b1;

    cyc(); chk("first_req", {31'd0, inst_req}, 32'd1);
    expect_acc(32'hBFC0_0000, 32'hBFC0_0004, 2'b11);
    cyc(); expect_acc(32'hBFC0_0008, 32'hBFC0_000C, 2'b11);
    cyc(); bp_bus = {1'b1, 32'h8000_1000}; next_inst_invalid = 1'b1;
    expect_acc(32'hBFC0_0010, 32'hBFC0_0014, 2'b01);
    cyc(); bp_bus = {1'b1, 32'h8000_1100}; next_inst_invalid = 1'b0;
    expect_acc(32'h8000_1000, 32'h8000_1004, 2'b11);

    // held request with branch redirect in first held cycle
    cyc(); bp_bus = 33'd0; inst_addr_ok = 1'b0; br_bus = {1'b1, 32'h8000_2000};
    #1 chk("kill_br", {31'd0, kill_inflight}, 32'd1);
    chk("hold_pc_a", current_pc1, 32'h8000_1100);
    cyc(); br_bus = 33'd0;
    #1 chk("kill_once", {31'd0, kill_inflight}, 32'd0);
    chk("hold_pc_b", current_pc1, 32'h8000_1100);
    chk("hold_req", {31'd0, inst_req}, 32'd1);
    cyc(); chk("hold_pc_c", current_pc1, 32'h8000_1100);
    cyc(); inst_addr_ok = 1'b1;
    expect_acc(32'h8000_1100, 32'h8000_1104, 2'b00);
    cyc(); expect_acc(32'h8000_2000, 32'h8000_2004, 2'b11);

    // pending branch overwritten by flush
    cyc(); inst_addr_ok = 1'b0; br_bus = {1'b1, 32'h8000_3000};
    cyc(); br_bus = 33'd0; flush = 1'b1; new_pc = 32'hBFC0_0380;
    #1 chk("kill_flush", {31'd0, kill_inflight}, 32'd1);
    cyc(); flush = 1'b0; inst_addr_ok = 1'b1;
    expect_acc(32'h8000_2008, 32'h8000_200C, 2'b00);

    // pending flush not overwritten by later branch
    cyc(); inst_addr_ok = 1'b0; flush = 1'b1; new_pc = 32'hBFC0_0400;
    chk("flush_target", current_pc1, 32'hBFC0_0380);
    cyc(); flush = 1'b0; br_bus = {1'b1, 32'h8000_4000};
    cyc(); br_bus = 33'd0; inst_addr_ok = 1'b1;
    expect_acc(32'hBFC0_0380, 32'hBFC0_0384, 2'b00);
    cyc(); expect_acc(32'hBFC0_0400, 32'hBFC0_0404, 2'b11);

    // drop to IDLE, then simultaneous flush + branch
    cyc(); stall = 1'b1;
    expect_acc(32'hBFC0_0408, 32'hBFC0_040C, 2'b11);
    cyc(); inst_addr_ok = 1'b0;
    chk("idle_req", {31'd0, inst_req}, 32'd0);
    chk("idle_pc", current_pc1, 32'hBFC0_0410);
    cyc(); flush = 1'b1; new_pc = 32'hBFC0_0500; br_bus = {1'b1, 32'h8000_5000};
    #1 chk("kill_idle", {31'd0, kill_inflight}, 32'd1);
    cyc(); flush = 1'b0; br_bus = 33'd0; stall = 1'b0;
    chk("idle_flush_pc", current_pc1, 32'hBFC0_0500);
    chk("idle_req2", {31'd0, inst_req}, 32'd0);
    cyc(); inst_addr_ok = 1'b1;
    chk("restart_req", {31'd0, inst_req}, 32'd1);
    expect_acc(32'hBFC0_0500, 32'hBFC0_0504, 2'b11);

    // wrap-around
    cyc(); flush = 1'b1; new_pc = 32'hFFFF_FFF8;
    expect_acc(32'hBFC0_0508, 32'hBFC0_050C, 2'b00);
    cyc(); flush = 1'b0;
    expect_acc(32'hFFFF_FFF8, 32'hFFFF_FFFC, 2'b11);
    cyc(); expect_acc(32'h0000_0000, 32'h0000_0004, 2'b11);

    // reset in the middle of a held request
    cyc(); inst_addr_ok = 1'b0; resetn = 1'b0;
    chk("pre_rst_pc", current_pc1, 32'h0000_0008);
    chk("pre_rst_req", {31'd0, inst_req}, 32'd1);
    cyc(); resetn = 1'b1; stall = 1'b1;
    chk("mid_rst_req", {31'd0, inst_req}, 32'd0);
    chk("mid_rst_pc", current_pc1, 32'hBFC0_0000);
    cyc();
    chk("leftover", exp_q.size(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
